// File: rtl/tt_sweep_checker_if.sv
// Handshake/result bundle between the sweep checker and its controller/function block.
interface tt_sweep_checker_if;
  logic         start;
  logic [6:0]   x;
  logic         f_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [127:0] tt_out;
  logic [7:0]   mismatch_cnt;
  logic         err_valid;
  logic [6:0]   first_err_idx;

  modport master (
    input  start, f_in,
    output x, busy, done, pass, tt_out, mismatch_cnt, err_valid, first_err_idx
  );

  modport slave (
    output start, f_in,
    input  x, busy, done, pass, tt_out, mismatch_cnt, err_valid, first_err_idx
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Sweeps all 128 minterms through a 7-input function block, captures its truth
// table and compares it against EXPECTED, reporting mismatch statistics.
module tt_sweep_checker #(
  parameter logic [127:0] EXPECTED = 128'hfeeeeeeafae8ea80fea8e8a0a8888880,
  parameter int           LAT      = 0
) (
  input logic              clk,
  input logic              rst,
  tt_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, FINISH} state_t;

  state_t       state;
  logic [6:0]   drive_idx;
  logic [2:0]   drain_cnt;
  logic         busy_r;
  logic         done_r;
  logic         pass_r;
  logic [127:0] tt_r;
  logic [7:0]   mm_cnt;
  logic         err_valid_r;
  logic [6:0]   first_idx;

  logic         cap_v;
  logic [6:0]   cap_idx;
  logic         cap_bad;
  logic         last_ok;

  // Capture point: either the minterm currently on x, or the one LAT edges old.
  generate
    if (LAT == 0) begin : g_comb
      assign cap_v   = (state == DRIVE);
      assign cap_idx = drive_idx;
    end else begin : g_pipe
      logic [LAT-1:0] pipe_v;
      logic [6:0]     pipe_idx [LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_v <= '0;
          for (int i = 0; i < LAT; i++) pipe_idx[i] <= '0;
        end else begin
          pipe_v[0]   <= (state == DRIVE);
          pipe_idx[0] <= drive_idx;
          for (int i = 1; i < LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
          end
        end
      end

      assign cap_v   = pipe_v[LAT-1];
      assign cap_idx = pipe_idx[LAT-1];
    end
  endgenerate

  assign cap_bad = cap_v && (bus.f_in != EXPECTED[cap_idx]);
  // The final sample lands on the same edge that enters FINISH, so fold it in.
  assign last_ok = !err_valid_r && !cap_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      drive_idx   <= '0;
      drain_cnt   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      tt_r        <= '0;
      mm_cnt      <= '0;
      err_valid_r <= 1'b0;
      first_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= DRIVE;
            drive_idx   <= '0;
            busy_r      <= 1'b1;
            pass_r      <= 1'b0;
            tt_r        <= '0;
            mm_cnt      <= '0;
            err_valid_r <= 1'b0;
            first_idx   <= '0;
          end
        end
        DRIVE: begin
          if (drive_idx == 7'd127) begin
            if (LAT > 0) begin
              state     <= DRAIN;
              drain_cnt <= 3'(LAT - 1);
            end else begin
              state  <= FINISH;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              pass_r <= last_ok;
            end
          end else begin
            drive_idx <= drive_idx + 7'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state  <= FINISH;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= last_ok;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        FINISH: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (cap_v) begin
        tt_r[cap_idx] <= bus.f_in;
        if (cap_bad) begin
          if (mm_cnt != 8'd128) mm_cnt <= mm_cnt + 8'd1;
          if (!err_valid_r) begin
            err_valid_r <= 1'b1;
            first_idx   <= cap_idx;
          end
        end
      end
    end
  end

  assign bus.x             = drive_idx;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.pass          = pass_r;
  assign bus.tt_out        = tt_r;
  assign bus.mismatch_cnt  = mm_cnt;
  assign bus.err_valid     = err_valid_r;
  assign bus.first_err_idx = first_idx;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: one LAT=0 instance, one LAT=3 instance,
// driven by selectable function-block models.
module tb_tt_sweep_checker;

  localparam logic [127:0] REF_TT = 128'hfeeeeeeafae8ea80fea8e8a0a8888880;

  logic clk;
  logic rst;
  int   mode;
  int   checks;
  int   errors;

  tt_sweep_checker_if ifa ();
  tt_sweep_checker_if ifb ();

  tt_sweep_checker #(.EXPECTED(REF_TT), .LAT(0)) dutA (.clk(clk), .rst(rst), .bus(ifa));
  tt_sweep_checker #(.EXPECTED(REF_TT), .LAT(3)) dutB (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modes: 0 reference, 1 tied 0, 2 tied 1, 3 minterm 0x55 inverted, 4 reference registered 3 cycles
  function automatic logic modelF(input int m, input logic [6:0] xNow, input logic [6:0] xDel);
    logic [127:0] t;
    t = REF_TT;
    case (m)
      0:       return t[xNow];
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return t[xNow] ^ (xNow == 7'h55);
      4:       return t[xDel];
      default: return 1'b0;
    endcase
  endfunction

  logic [6:0] aD1, aD2, aD3, bD1, bD2, bD3;
  always @(posedge clk) begin
    aD1 <= ifa.x; aD2 <= aD1; aD3 <= aD2;
    bD1 <= ifb.x; bD2 <= bD1; bD3 <= bD2;
  end

  assign ifa.f_in = modelF(mode, ifa.x, aD3);
  assign ifb.f_in = modelF(mode, ifb.x, bD3);

  typedef struct {
    int           mode;
    bit           useB;
    bit           spam;
    int           busyCyc;
    bit           expPass;
    bit           chkDetail;
    int           expCnt;
    bit           expErr;
    int           expFirst;
    bit           chkTt;
    logic [127:0] expTt;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic getRes(input bit useB, output logic p, output logic [7:0] c, output logic e,
                        output logic [6:0] f, output logic [127:0] t, output logic d, output logic b);
    p = useB ? ifb.pass          : ifa.pass;
    c = useB ? ifb.mismatch_cnt  : ifa.mismatch_cnt;
    e = useB ? ifb.err_valid     : ifa.err_valid;
    f = useB ? ifb.first_err_idx : ifa.first_err_idx;
    t = useB ? ifb.tt_out        : ifa.tt_out;
    d = useB ? ifb.done          : ifa.done;
    b = useB ? ifb.busy          : ifa.busy;
  endtask

  // Pulses start, counts busy cycles and returns positioned in the done cycle.
  task automatic applyStimulus(input bit useB, input bit spam, output int busyCyc, output bit gotDone);
    busyCyc = 0;
    gotDone = 1'b0;
    @(negedge clk);
    if (useB) ifb.start = 1'b1; else ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    for (int cyc = 0; cyc < 400 && !gotDone; cyc++) begin
      if (useB ? ifb.done : ifa.done) begin
        gotDone = 1'b1;
      end else begin
        if (useB ? ifb.busy : ifa.busy) busyCyc++;
        if (useB) ifb.start = spam && (cyc == 20 || cyc == 90);
        else      ifa.start = spam && (cyc == 20 || cyc == 90);
        @(negedge clk);
      end
    end
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic waitDoneA(output bit gotDone);
    gotDone = 1'b0;
    for (int cyc = 0; cyc < 400 && !gotDone; cyc++) begin
      if (ifa.done) gotDone = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    logic         p, e, d, b;
    logic [7:0]   c;
    logic [6:0]   f;
    logic [127:0] t;
    int           busyCyc;
    bit           gotDone;
    bit           sawDone;

    checks = 0;
    errors = 0;
    mode = 0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;

    vecs[0] = '{mode:0, useB:0, spam:0, busyCyc:128, expPass:1, chkDetail:1, expCnt:0,  expErr:0, expFirst:0,     chkTt:1, expTt:REF_TT};
    vecs[1] = '{mode:1, useB:0, spam:0, busyCyc:128, expPass:0, chkDetail:1, expCnt:64, expErr:1, expFirst:7,     chkTt:1, expTt:'0};
    vecs[2] = '{mode:2, useB:0, spam:0, busyCyc:128, expPass:0, chkDetail:1, expCnt:64, expErr:1, expFirst:0,     chkTt:1, expTt:{128{1'b1}}};
    vecs[3] = '{mode:4, useB:1, spam:0, busyCyc:131, expPass:1, chkDetail:1, expCnt:0,  expErr:0, expFirst:0,     chkTt:1, expTt:REF_TT};
    vecs[4] = '{mode:4, useB:0, spam:0, busyCyc:128, expPass:0, chkDetail:0, expCnt:0,  expErr:0, expFirst:0,     chkTt:0, expTt:'0};
    vecs[5] = '{mode:3, useB:0, spam:1, busyCyc:128, expPass:0, chkDetail:1, expCnt:1,  expErr:1, expFirst:'h55,  chkTt:1, expTt:REF_TT ^ (128'd1 << 85)};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    getRes(1'b0, p, c, e, f, t, d, b);
    checkOutput("reset_x", ifa.x, 0);
    checkOutput("reset_busy", b, 0);
    checkOutput("reset_done", d, 0);
    checkOutput("reset_pass", p, 0);
    checkOutput("reset_tt", t, 0);
    checkOutput("reset_cnt", c, 0);
    checkOutput("reset_err", e, 0);
    checkOutput("reset_first", f, 0);

    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      applyStimulus(vecs[i].useB, vecs[i].spam, busyCyc, gotDone);
      checkOutput($sformatf("v%0d_done", i), gotDone, 1);
      checkOutput($sformatf("v%0d_busy_cycles", i), busyCyc, vecs[i].busyCyc);
      getRes(vecs[i].useB, p, c, e, f, t, d, b);
      checkOutput($sformatf("v%0d_pass", i), p, vecs[i].expPass);
      if (vecs[i].chkDetail) begin
        checkOutput($sformatf("v%0d_cnt", i), c, vecs[i].expCnt);
        checkOutput($sformatf("v%0d_err", i), e, vecs[i].expErr);
        checkOutput($sformatf("v%0d_first", i), f, vecs[i].expFirst);
      end
      if (vecs[i].chkTt) checkOutput($sformatf("v%0d_tt", i), t, vecs[i].expTt);
      @(negedge clk);
      getRes(vecs[i].useB, p, c, e, f, t, d, b);
      checkOutput($sformatf("v%0d_done_width", i), d, 0);
      repeat (3) @(negedge clk);
      getRes(vecs[i].useB, p, c, e, f, t, d, b);
      checkOutput($sformatf("v%0d_idle_after", i), b, 0);
      checkOutput($sformatf("v%0d_pass_hold", i), p, vecs[i].expPass);
    end

    // Reset in the middle of a sweep discards everything
    mode = 0;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    getRes(1'b0, p, c, e, f, t, d, b);
    checkOutput("midrst_x", ifa.x, 0);
    checkOutput("midrst_busy", b, 0);
    checkOutput("midrst_tt", t, 0);
    checkOutput("midrst_done", d, 0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (ifa.done || ifa.busy) sawDone = 1'b1;
    end
    checkOutput("midrst_no_done", sawDone, 0);
    applyStimulus(1'b0, 1'b0, busyCyc, gotDone);
    checkOutput("postrst_done", gotDone, 1);
    checkOutput("postrst_busy_cycles", busyCyc, 128);
    getRes(1'b0, p, c, e, f, t, d, b);
    checkOutput("postrst_pass", p, 1);
    checkOutput("postrst_tt", t, REF_TT);

    // Start held high gives back-to-back sweeps
    @(negedge clk);
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    waitDoneA(gotDone);
    checkOutput("b2b_first_done", gotDone, 1);
    @(negedge clk);
    checkOutput("b2b_idle_gap", ifa.busy, 0);
    @(negedge clk);
    checkOutput("b2b_restart", ifa.busy, 1);
    ifa.start = 1'b0;
    waitDoneA(gotDone);
    checkOutput("b2b_second_done", gotDone, 1);
    checkOutput("b2b_second_pass", ifa.pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
